map_selector: RTL and testbench

Responder to the game controller's map requests in the tank-game VGA pipeline. It picks a map index from a free-running LFSR when the controller signals `randomPick` (game start) or `pickMap` (periodic map change). It then copies the chosen map's tiles from the map ROM into the live tile RAM read by the drawing logic. `mapReady` tells the rest of the design that the tile RAM holds a complete, consistent map.

---
 rtl/map_selector.sv | 200 ++++++++++++++++++++
 tb/tb_map_selector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_selector.sv
// map_selector: picks a map index from a free-running LFSR on a controller
// request and copies that map's tiles from the map ROM into the live tile RAM.
// mapReady marks the tile RAM as holding one complete, consistent map.
// Optional feature macro: MAP_SELECTOR_NO_REPEAT_EN (pickMap never re-selects
// the map that is currently loaded when more than one map exists).
module map_selector #(
    parameter int          NUM_MAPS  = 4,
    parameter int          MAP_W     = 16,
    parameter int          MAP_H     = 12,
    parameter int          TILE_BITS = 2,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    localparam int         TILES     = MAP_W * MAP_H,
    localparam int         IDX_W     = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1,
    localparam int         ROM_W     = $clog2(NUM_MAPS * TILES),
    localparam int         T_W       = $clog2(TILES)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 randomPick,
    input  logic                 pickMap,
    output logic [IDX_W-1:0]     mapIndex,
    output logic [ROM_W-1:0]     romAddr,
    input  logic [TILE_BITS-1:0] romData,
    output logic                 ramWrEn,
    output logic [T_W-1:0]       ramAddr,
    output logic [TILE_BITS-1:0] ramWrData,
    output logic                 mapReady,
    output logic                 loadDone
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Feedback bit for x^8+x^6+x^5+x^4+1 (parity of the tapped bits).
    function automatic logic lfsr_fb(input logic [7:0] v);
        return v[7] ^ v[5] ^ v[4] ^ v[3];
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic [7:0]           lfsr_r;
    logic [IDX_W-1:0]     cand_s;
    logic [IDX_W-1:0]     sel_idx_s;
    logic                 req_s;
    logic                 last_tile_s;

    logic [T_W-1:0]       t_r;
    logic [T_W-1:0]       t_next_s;
    logic [IDX_W-1:0]     map_index_r;
    logic [IDX_W-1:0]     idx_next_s;
    logic [ROM_W-1:0]     rom_addr_r;
    logic [ROM_W-1:0]     rom_addr_next_s;
    logic                 wr_en_r;
    logic                 wr_en_next_s;
    logic [T_W-1:0]       ram_addr_r;
    logic [T_W-1:0]       ram_addr_next_s;
    logic                 ready_r;
    logic                 ready_next_s;
    logic                 done_r;
    logic                 done_next_s;

    assign req_s       = randomPick | pickMap;
    assign last_tile_s = (t_r == T_W'(TILES - 1));
    assign cand_s      = IDX_W'(int'(lfsr_r) % NUM_MAPS);

    // Free-running LFSR; it keeps stepping during loads so picks stay varied.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_fb(lfsr_r)};
        end
    end

`ifdef MAP_SELECTOR_NO_REPEAT_EN
    logic [IDX_W-1:0] bump_idx_s;

    // Successor of the current map index, wrapping at NUM_MAPS.
    always_comb begin
        bump_idx_s = map_index_r + IDX_W'(1);
        if (map_index_r == IDX_W'(NUM_MAPS - 1)) begin
            bump_idx_s = '0;
        end else begin
            bump_idx_s = map_index_r + IDX_W'(1);
        end
    end

    // Index selection: a pickMap that would repeat the current map steps past it;
    // randomPick (which wins when both are high) always takes the LFSR candidate.
    always_comb begin
        sel_idx_s = cand_s;
        if (!randomPick && pickMap && (cand_s == map_index_r)) begin
            sel_idx_s = bump_idx_s;
        end else begin
            sel_idx_s = cand_s;
        end
    end
`else
    // Index selection: both request kinds take the LFSR candidate unmodified.
    always_comb begin
        sel_idx_s = cand_s;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: any request (re)starts a fetch from tile 0.
    always_comb begin
        state_next_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (req_s) state_next_s = S_FETCH;
                else       state_next_s = S_IDLE;
            end
            S_FETCH: begin
                if (req_s)            state_next_s = S_FETCH;
                else if (last_tile_s) state_next_s = S_FLUSH;
                else                  state_next_s = S_FETCH;
            end
            S_FLUSH: begin
                if (req_s) state_next_s = S_FETCH;
                else       state_next_s = S_IDLE;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered datapath and flags.
    always_comb begin
        idx_next_s      = map_index_r;
        t_next_s        = t_r;
        ready_next_s    = ready_r;
        done_next_s     = 1'b0;
        wr_en_next_s    = 1'b0;
        ram_addr_next_s = t_r;
        if (req_s) begin
            idx_next_s   = sel_idx_s;
            t_next_s     = '0;
            ready_next_s = 1'b0;
        end else begin
            idx_next_s = map_index_r;
            case (state_r)
                S_FETCH: begin
                    wr_en_next_s = 1'b1;
                    if (last_tile_s) t_next_s = t_r;
                    else             t_next_s = t_r + T_W'(1);
                end
                S_FLUSH: begin
                    ready_next_s = 1'b1;
                    done_next_s  = 1'b1;
                end
                default: begin
                    t_next_s = t_r;
                end
            endcase
        end
        rom_addr_next_s = ROM_W'(idx_next_s) * ROM_W'(TILES) + ROM_W'(t_next_s);
    end

    // Registered datapath and status outputs; the write strobe and address are
    // the fetch address delayed one cycle to line up with the ROM read latency.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            map_index_r <= '0;
            t_r         <= '0;
            rom_addr_r  <= '0;
            wr_en_r     <= 1'b0;
            ram_addr_r  <= '0;
            ready_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            map_index_r <= idx_next_s;
            t_r         <= t_next_s;
            rom_addr_r  <= rom_addr_next_s;
            wr_en_r     <= wr_en_next_s;
            ram_addr_r  <= ram_addr_next_s;
            ready_r     <= ready_next_s;
            done_r      <= done_next_s;
        end
    end

    assign mapIndex  = map_index_r;
    assign romAddr   = rom_addr_r;
    assign ramWrEn   = wr_en_r;
    assign ramAddr   = ram_addr_r;
    assign ramWrData = romData;
    assign mapReady  = ready_r;
    assign loadDone  = done_r;

endmodule

// File: tb/tb_map_selector.sv
// Scoreboard bench for map_selector: instance A uses the defaults (4 maps),
// instance B uses a single map. Build with +define+MAP_SELECTOR_NO_REPEAT_EN
// to exercise the no-repeat variant; the expected values follow the macro.
module tb_map_selector;
    localparam int TILES = 192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       rp_a, pm_a, rp_b, pm_b;
    logic [1:0] idx_a;
    logic [9:0] rom_addr_a;
    logic [1:0] rom_data_a, wr_data_a;
    logic       wr_a, ready_a, done_a;
    logic [7:0] ram_addr_a;
    logic [0:0] idx_b;
    logic [7:0] rom_addr_b;
    logic [1:0] rom_data_b, wr_data_b;
    logic       wr_b, ready_b, done_b;
    logic [7:0] ram_addr_b;

    map_selector dut_a (
        .clk(clk), .resetN(reset_n), .randomPick(rp_a), .pickMap(pm_a),
        .mapIndex(idx_a), .romAddr(rom_addr_a), .romData(rom_data_a),
        .ramWrEn(wr_a), .ramAddr(ram_addr_a), .ramWrData(wr_data_a),
        .mapReady(ready_a), .loadDone(done_a)
    );

    map_selector #(.NUM_MAPS(1)) dut_b (
        .clk(clk), .resetN(reset_n), .randomPick(rp_b), .pickMap(pm_b),
        .mapIndex(idx_b), .romAddr(rom_addr_b), .romData(rom_data_b),
        .ramWrEn(wr_b), .ramAddr(ram_addr_b), .ramWrData(wr_data_b),
        .mapReady(ready_b), .loadDone(done_b)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ROM contents: an address hash so each map and tile has distinct data.
    function automatic logic [1:0] rom_fn(input int a);
        int v;
        v = a ^ (a >> 3) ^ (a >> 5);
        return v[1:0];
    endfunction

    // ROM model with one clock of read latency.
    always @(posedge clk) begin
        rom_data_a <= rom_fn(int'(rom_addr_a));
        rom_data_b <= rom_fn(int'(rom_addr_b));
    end

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 8'hA5.
    logic [7:0] m_lfsr = 8'hA5;
    always @(posedge clk) begin
        if (!reset_n) m_lfsr <= 8'hA5;
        else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // What each DUT sampled at the last rising edge.
    logic req_s_a = 1'b0, req_s_b = 1'b0, rst_s = 1'b0;
    always @(posedge clk) begin
        req_s_a <= rp_a | pm_a;
        req_s_b <= rp_b | pm_b;
        rst_s   <= ~reset_n;
    end

    int exp_q_a[$];
    int exp_q_b[$];
    int cur_idx = 0;

    // ---------------- Monitor A ----------------
    bit  loading_a = 1'b0;
    bit  ready_exp_a = 1'b0;
    bit  done_exp_a;
    int  cyc_a = 0;
    int  base_seen_a = 0;
    int  stray_a = 0;
    int  trk_err_a = 0;
    int  wr_addr_q[$];
    int  wr_data_q[$];

    always @(negedge clk) begin
        int e, bad;
        if (rst_s) begin
            check("reset_state", 32'({idx_a, rom_addr_a, wr_a, ram_addr_a, ready_a, done_a}), 32'd0);
            loading_a   = 1'b0;
            ready_exp_a = 1'b0;
            cyc_a       = 0;
            wr_addr_q.delete();
            wr_data_q.delete();
        end else begin
            if (req_s_a) begin
                loading_a   = 1'b1;
                cyc_a       = 0;
                ready_exp_a = 1'b0;
                base_seen_a = int'(rom_addr_a);
                wr_addr_q.delete();
                wr_data_q.delete();
                check("no_write_on_request", 32'(wr_a), 32'd0);
            end else if (loading_a) begin
                cyc_a++;
            end
            done_exp_a = loading_a && !req_s_a && (cyc_a == TILES + 1);
            if (done_exp_a) ready_exp_a = 1'b1;
            if (done_a !== done_exp_a || ready_a !== ready_exp_a) begin
                trk_err_a++;
                if (trk_err_a <= 5)
                    $display("FAIL ready_track at %0t: loadDone %b mapReady %b, expected %b %b",
                             $time, done_a, ready_a, done_exp_a, ready_exp_a);
            end
            if (wr_a === 1'b1) begin
                if (loading_a) begin
                    wr_addr_q.push_back(int'(ram_addr_a));
                    wr_data_q.push_back(int'(wr_data_a));
                end else begin
                    stray_a++;
                end
            end
            if (done_a === 1'b1) begin
                if (exp_q_a.size() == 0) begin
                    check("unexpected_load_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q_a.pop_front();
                    check("map_index", 32'(idx_a), 32'(e));
                    check("rom_base", 32'(base_seen_a), 32'(e * TILES));
                    check("write_count", 32'(wr_addr_q.size()), 32'(TILES));
                    bad = 0;
                    foreach (wr_addr_q[i])
                        if (wr_addr_q[i] != i || wr_data_q[i] != int'(rom_fn(e * TILES + i))) bad++;
                    check("write_contents_bad", 32'(bad), 32'd0);
                    check("load_latency", 32'(cyc_a), 32'(TILES + 1));
                end
                loading_a = 1'b0;
            end
        end
    end

    // ---------------- Monitor B ----------------
    int wcnt_b = 0;
    int done_cnt_b = 0;
    always @(negedge clk) begin
        int e;
        if (rst_s) begin
            wcnt_b = 0;
        end else begin
            if (req_s_b) wcnt_b = 0;
            if (wr_b === 1'b1) wcnt_b++;
            if (done_b === 1'b1) begin
                done_cnt_b++;
                if (exp_q_b.size() == 0) begin
                    check("b_unexpected_load_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q_b.pop_front();
                    check("b_map_index", 32'(idx_b), 32'(e));
                    check("b_write_count", 32'(wcnt_b), 32'(TILES));
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    // Called just after a falling edge: drives a one-cycle request that the
    // next rising edge samples, predicting the chosen index from the model LFSR.
    task automatic request_a(input bit rp, input bit pm, input bit completes);
        int cand, e;
        cand = int'(m_lfsr) % 4;
        if (rp) begin
            e = cand;
        end else begin
`ifdef MAP_SELECTOR_NO_REPEAT_EN
            e = (cand == cur_idx) ? (cur_idx + 1) % 4 : cand;
`else
            e = cand;
`endif
        end
        cur_idx = e;
        if (completes) exp_q_a.push_back(e);
        rp_a = rp;
        pm_a = pm;
        @(negedge clk);
        rp_a = 1'b0;
        pm_a = 1'b0;
    endtask

    // Waits (bounded) until the LFSR candidate equals the target index.
    task automatic wait_cand(input int target);
        for (int i = 0; i < 300; i++) begin
            if (int'(m_lfsr) % 4 == target) return;
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rp_a = 1'b0; pm_a = 1'b0; rp_b = 1'b0; pm_b = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Plain start-of-game load.
        request_a(1'b1, 1'b0, 1'b1);
        repeat (200) @(negedge clk);

        // Repeat candidate while the current index is 3.
        wait_cand(3);
        request_a(1'b1, 1'b0, 1'b1);
        repeat (200) @(negedge clk);
        wait_cand(3);
        request_a(1'b0, 1'b1, 1'b1);
        repeat (200) @(negedge clk);

        // Repeat candidate while the current index is 2.
        wait_cand(2);
        request_a(1'b1, 1'b0, 1'b1);
        repeat (200) @(negedge clk);
        wait_cand(2);
        request_a(1'b0, 1'b1, 1'b1);
        repeat (200) @(negedge clk);

        // Abort around write 100, restarted by pickMap.
        request_a(1'b1, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        request_a(1'b0, 1'b1, 1'b1);
        repeat (200) @(negedge clk);

        // Both requests together while the candidate repeats: randomPick wins.
        wait_cand(cur_idx);
        request_a(1'b1, 1'b1, 1'b1);
        repeat (200) @(negedge clk);

        // Reset for one edge around write 50.
        request_a(1'b1, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cur_idx = 0;
        repeat (20) @(negedge clk);

        // Recovery load after reset.
        request_a(1'b1, 1'b0, 1'b1);
        repeat (200) @(negedge clk);

        // Single-map instance: three map changes, each a full reload of map 0.
        for (int k = 0; k < 3; k++) begin
            exp_q_b.push_back(0);
            pm_b = 1'b1;
            @(negedge clk);
            pm_b = 1'b0;
            repeat (200) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("a_pending_loads", 32'(exp_q_a.size()), 32'd0);
        check("a_stray_writes", 32'(stray_a), 32'd0);
        check("a_ready_track_errors", 32'(trk_err_a), 32'd0);
        check("b_pending_loads", 32'(exp_q_b.size()), 32'd0);
        check("b_load_done_count", 32'(done_cnt_b), 32'd3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
